// File: rtl/debounce_fsm.sv
// Switch debouncer: a four-state Moore FSM with a down-counter accepts a level change only
// after sw has held for DB_TICKS cycles. Define DEBOUNCE_SYNC_EN to add a two-flop synchronizer on sw.
module debounce_fsm #(
  parameter int DB_TICKS = 1000000,
  parameter int CNT_W    = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic busy
);

  // Bit 1 is the debounced level and bit 0 marks a wait state, so both outputs come straight from flops.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_TICKS - 1);

  if ((DB_TICKS < 1) || (longint'(DB_TICKS) > (longint'(1) << CNT_W))) begin : g_bad_ticks
    $error("debounce_fsm: DB_TICKS=%0d outside 1..2^CNT_W (CNT_W=%0d)", DB_TICKS, CNT_W);
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sw_s;

`ifdef DEBOUNCE_SYNC_EN
  logic r_sync_p0;
  logic r_sync_p1;

  // Synchronizer stages
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= sw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_sw_s = r_sync_p1;
`else
  assign w_sw_s = sw;
`endif

  // FSM state and counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ZERO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ZERO: begin
        if (w_sw_s) begin
          w_state_nxt = WAIT1;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!w_sw_s) begin
          w_state_nxt = ZERO;
        end else if (r_cnt == '0) begin
          w_state_nxt = ONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ONE: begin
        if (!w_sw_s) begin
          w_state_nxt = WAIT0;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (w_sw_s) begin
          w_state_nxt = ONE;
        end else if (r_cnt == '0) begin
          w_state_nxt = ZERO;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ZERO;
      end
    endcase
  end

  assign db_level = r_state[1];
  assign busy     = r_state[0];

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with DB_TICKS=4, CNT_W=3; expectations shift by two
// cycles when DEBOUNCE_SYNC_EN is defined.
module tb_debounce_fsm;

`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic reset_n;
  logic sw;
  logic db_level;
  logic busy;

  int checks;
  int errors;

  debounce_fsm #(.DB_TICKS(4), .CNT_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (sw),
    .db_level (db_level),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drop sw and wait out the full release so the FSM sits in ZERO.
  task automatic settle_low();
    sw = 1'b0;
    repeat (5 + LAT) tick();
    chk("settle_db", db_level, 1'b0);
    chk("settle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [5:0] bounce;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    sw      = 1'b1;

    // Scenario 1: reset held with sw high, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_db", db_level, 1'b0);
      chk("rst_busy", busy, 1'b0);
    end
    reset_n = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("rel_busy_e1", busy, 1'b1);
    chk("rel_db_e1", db_level, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_db_wait", db_level, 1'b0);
    end
    tick();
    chk("rel_db_rise", db_level, 1'b1);
    chk("rel_busy_done", busy, 1'b0);

    // Scenario 2: clean press
    settle_low();
    sw = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("press_busy_e", busy, 1'b1);
    chk("press_db_e", db_level, 1'b0);
    repeat (3) tick();
    chk("press_db_e3", db_level, 1'b0);
    chk("press_busy_e3", busy, 1'b1);
    tick();
    chk("press_db_e4", db_level, 1'b1);
    chk("press_busy_e4", busy, 1'b0);

    // Scenario 3: bounce 1,0,1,1,0,1 then hold 1
    settle_low();
    bounce = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      sw = bounce[i];
      tick();
      chk("bounce_db", db_level, 1'b0);
    end
    sw = 1'b1;
    for (int i = 0; i < 3 + LAT; i++) begin
      tick();
      chk("bounce_hold_db", db_level, 1'b0);
    end
    tick();
    chk("bounce_rise", db_level, 1'b1);

    // Scenario 4: release with a one-edge glitch back high
    sw = 1'b0; tick(); chk("rel_g_db0", db_level, 1'b1);
    tick();             chk("rel_g_db1", db_level, 1'b1);
    sw = 1'b1; tick(); chk("rel_g_db2", db_level, 1'b1);
    sw = 1'b0; tick(); chk("rel_g_db3", db_level, 1'b1);
    for (int i = 0; i < 3 + LAT; i++) begin
      tick();
      chk("rel_g_hold_db", db_level, 1'b1);
    end
    tick();
    chk("rel_g_fall", db_level, 1'b0);
    chk("rel_g_busy", busy, 1'b0);

    // Scenario 5: reset in the middle of WAIT1 (cnt=2)
    sw = 1'b1;
    repeat (LAT) tick();
    tick();
    tick();
    chk("mid_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_db", db_level, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("mid_busy_new", busy, 1'b1);
    chk("mid_db_new", db_level, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_db_wait", db_level, 1'b0);
    end
    tick();
    chk("mid_db_rise", db_level, 1'b1);
    chk("mid_busy_done", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
